// File: rtl/kgp_pkg.sv
// Shared KGP (kill/generate/propagate) encoding and sizing helpers for the
// Kogge-Stone subtractor pipeline.
package kgp_pkg;

    localparam logic [1:0] KGP_KILL = 2'b00;
    localparam logic [1:0] KGP_GEN  = 2'b11;
    localparam logic [1:0] KGP_PROP = 2'b01;

    // Number of prefix levels needed to resolve WIDTH carry positions.
    function automatic int unsigned kgp_levels(input int unsigned width);
        int unsigned lv;
        lv = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < width) lv = i + 1;
        end
        return lv;
    endfunction

    // Both propagate spellings (01, 10) count as propagate.
    function automatic logic kgp_is_prop(input logic [1:0] c);
        return (c == KGP_PROP) || (c == ~KGP_PROP);
    endfunction

    // A fully resolved prefix term is either GEN (carry 1) or KILL (carry 0).
    function automatic logic kgp_carry(input logic [1:0] c);
        return c == KGP_GEN;
    endfunction

endpackage

// File: rtl/kgp_merge.sv
// Combinational combine of a (higher, lower) KGP pair: a propagating higher
// segment takes the lower segment's status, otherwise it decides on its own.
module kgp_merge
    import kgp_pkg::*;
(
    input  logic [1:0] hi,
    input  logic [1:0] lo,
    output logic [1:0] res_c
);

    always_comb begin
        res_c = hi;
        if (kgp_is_prop(hi)) res_c = lo;
    end

endmodule

// File: rtl/kgp_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin with borrow, zero,
// negative and signed-overflow flags; valid/ready with a global stall enable.
module kgp_sub_pipe
    import kgp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned LEVELS = kgp_levels(WIDTH);
    localparam int unsigned NSTG   = LEVELS + 1;

    // Stage 0 holds the raw per-position terms; stage k holds prefix level k.
    // Position 0 is carry-in, position i is bit i-1, so position i resolves
    // to the carry into bit i.
    logic                  valid_q [NSTG];
    logic                  valid_d [NSTG];
    logic [WIDTH-1:0][1:0] code_q  [NSTG];
    logic [WIDTH-1:0][1:0] code_d  [NSTG];
    logic [WIDTH-1:0]      a_q     [NSTG];
    logic [WIDTH-1:0]      a_d     [NSTG];
    logic [WIDTH-1:0]      b_q     [NSTG];
    logic [WIDTH-1:0]      b_d     [NSTG];
    logic [WIDTH-1:0]      p_q     [NSTG];
    logic [WIDTH-1:0]      p_d     [NSTG];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic             en_c;
    logic [1:0]       merged_c [1:LEVELS][WIDTH];
    logic [WIDTH-1:0] carry_c;
    logic [WIDTH-1:0] diff_c;
    logic             cout_c;
    logic             zero_c;
    logic             ovf_c;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int unsigned SPAN = 1 << (k - 1);
        for (genvar j = 0; j < WIDTH; j++) begin : g_pos
            if (j >= SPAN) begin : g_merge
                kgp_merge u_merge (
                    .hi   (code_q[k-1][j]),
                    .lo   (code_q[k-1][j-SPAN]),
                    .res_c(merged_c[k][j])
                );
            end else begin : g_pass
                assign merged_c[k][j] = code_q[k-1][j];
            end
        end
    end

    // Result from resolved carries. Zero is detected straight from the
    // operands: the sum is all-zero exactly when every p_i equals the carry
    // that an all-zero sum would imply (cin at bit 0, a|~b one bit lower).
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry_c[i] = kgp_carry(code_q[LEVELS][i]);
        end
        diff_c = p_q[LEVELS] ^ carry_c;
        cout_c = (a_q[LEVELS][WIDTH-1] & ~b_q[LEVELS][WIDTH-1])
               | (p_q[LEVELS][WIDTH-1] & carry_c[WIDTH-1]);
        zero_c = (p_q[LEVELS] == {a_q[LEVELS][WIDTH-2:0] | ~b_q[LEVELS][WIDTH-2:0], carry_c[0]});
        ovf_c  = (a_q[LEVELS][WIDTH-1] != b_q[LEVELS][WIDTH-1])
              && (diff_c[WIDTH-1] != a_q[LEVELS][WIDTH-1]);
    end

    always_comb begin
        en_c        = !out_valid_q || out_ready;
        valid_d     = valid_q;
        code_d      = code_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        if (en_c) begin
            valid_d[0]   = in_valid;
            code_d[0][0] = bin ? KGP_KILL : KGP_GEN;
            for (int unsigned i = 1; i < WIDTH; i++) begin
                code_d[0][i] = {a[i-1], ~b[i-1]};
            end
            a_d[0] = a;
            b_d[0] = b;
            p_d[0] = a ^ ~b;
            for (int unsigned k = 1; k <= LEVELS; k++) begin
                valid_d[k] = valid_q[k-1];
                a_d[k]     = a_q[k-1];
                b_d[k]     = b_q[k-1];
                p_d[k]     = p_q[k-1];
                for (int unsigned j = 0; j < WIDTH; j++) begin
                    code_d[k][j] = merged_c[k][j];
                end
            end
            out_valid_d = valid_q[LEVELS];
            if (valid_q[LEVELS]) begin
                diff_d = diff_c;
                bout_d = !cout_c;
                zero_d = zero_c;
                neg_d  = diff_c[WIDTH-1];
                ovf_d  = ovf_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned k = 0; k < NSTG; k++) begin
                valid_q[k] <= 1'b0;
                code_q[k]  <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                p_q[k]     <= '0;
            end
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            code_q      <= code_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = en_c;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_kgp_sub_pipe.sv
// Bench for kgp_sub_pipe at WIDTH=8 and WIDTH=16: directed vectors, stall and
// reset sequences, then random traffic against a queue-based reference.
module tb_kgp_sub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        iv8, ir8, ov8, or8, bin8, bout8, zero8, neg8, ovf8;
    logic [7:0]  a8, b8, diff8;
    logic        iv16, ir16, ov16, or16, bin16, bout16, zero16, neg16, ovf16;
    logic [15:0] a16, b16, diff16;

    kgp_sub_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(or8),
        .diff(diff8), .bout(bout8), .zero(zero8), .neg(neg8), .ovf(ovf8)
    );

    kgp_sub_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .resetn(resetn), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .bin(bin16), .out_valid(ov16), .out_ready(or16),
        .diff(diff16), .bout(bout16), .zero(zero16), .neg(neg16), .ovf(ovf16)
    );

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        zero;
        logic        neg;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       neg;
        logic       ovf;
    } vec_t;

    res_t q8[$];
    res_t q16[$];
    int   checks = 0;
    int   errors = 0;
    int   n8 = 0, n16 = 0;
    int   res8 = 0, res16 = 0;

    function automatic res_t model(input int unsigned w, input logic [31:0] a,
                                   input logic [31:0] b, input logic bin);
        logic [32:0] full;
        logic [31:0] mask;
        res_t        r;
        mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full   = {1'b0, a & mask} - {1'b0, b & mask} - 33'(bin);
        r.diff = full[31:0] & mask;
        r.bout = full[w];
        r.zero = (r.diff == 32'd0);
        r.neg  = r.diff[w-1];
        r.ovf  = (a[w-1] != b[w-1]) && (r.diff[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_res(input string name, input logic [31:0] d, input logic bo,
                           input logic z, input logic n, input logic o, input res_t e);
        chk(name, 64'({d, bo, z, n, o}), 64'({e.diff, e.bout, e.zero, e.neg, e.ovf}));
    endtask

    // One clock: drive at the falling edge, check, book-keep, wait a cycle.
    task automatic cyc(input logic v8, input logic [7:0] xa8, input logic [7:0] xb8,
                       input logic xbin8, input logic r8,
                       input logic v16, input logic [15:0] xa16, input logic [15:0] xb16,
                       input logic xbin16, input logic r16);
        logic acc8, acc16;
        iv8 = v8;   a8 = xa8;   b8 = xb8;   bin8 = xbin8;   or8 = r8;
        iv16 = v16; a16 = xa16; b16 = xb16; bin16 = xbin16; or16 = r16;
        #1;
        chk("in_ready8", 64'(ir8), 64'(!ov8 || r8));
        chk("in_ready16", 64'(ir16), 64'(!ov16 || r16));
        acc8  = v8 && (!ov8 || r8);
        acc16 = v16 && (!ov16 || r16);
        if (ov8) begin
            if (q8.size() == 0) chk("unexpected_out8", 64'(ov8), 64'(0));
            else begin
                cmp_res("res8", 32'(diff8), bout8, zero8, neg8, ovf8, q8[0]);
                if (r8) begin void'(q8.pop_front()); res8++; end
            end
        end
        if (ov16) begin
            if (q16.size() == 0) chk("unexpected_out16", 64'(ov16), 64'(0));
            else begin
                cmp_res("res16", 32'(diff16), bout16, zero16, neg16, ovf16, q16[0]);
                if (r16) begin void'(q16.pop_front()); res16++; end
            end
        end
        if (acc8) begin q8.push_back(model(8, 32'(xa8), 32'(xb8), xbin8)); n8++; end
        if (acc16) begin q16.push_back(model(16, 32'(xa16), 32'(xb16), xbin16)); n16++; end
        @(negedge clk);
    endtask

    task automatic cyc8(input logic v, input logic [7:0] xa, input logic [7:0] xb,
                        input logic xbin, input logic r);
        cyc(v, xa, xb, xbin, r, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic idle_inputs();
        iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; or8 = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0; or16 = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        int   base;
        int   guard;
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};

        resetn = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_out8", 64'({ov8, diff8, bout8, zero8, neg8, ovf8}), 64'(0));
        chk("rst_out16", 64'({ov16, diff16, bout16, zero16, neg16, ovf16}), 64'(0));
        chk("rst_ready8", 64'(ir8), 64'(1));
        chk("rst_ready16", 64'(ir16), 64'(1));
        @(negedge clk);

        // Directed vectors: latency and hand-derived results.
        for (int i = 0; i < 8; i++) begin
            cyc8(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1);
            lat = 1;
            while (!ov8 && lat < 12) begin
                cyc8(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
                lat++;
            end
            chk($sformatf("latency[%0d]", i), 64'(lat), 64'(5));
            chk($sformatf("vec[%0d]", i), 64'({diff8, bout8, zero8, neg8, ovf8}),
                64'({vecs[i].diff, vecs[i].bout, vecs[i].zero, vecs[i].neg, vecs[i].ovf}));
            cyc8(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        end

        // Five back-to-back operands with a three-cycle consumer stall.
        base = res8;
        for (int c = 0; c < 20; c++) begin
            if (c >= 6 && c <= 8) begin
                or8 = 1'b0;
                #1;
                chk("stall_valid", 64'(ov8), 64'(1));
                chk("stall_ready", 64'(ir8), 64'(0));
            end
            cyc8(c < 5, 8'(8'h31 * c + 8'h07), 8'(8'h5B * c), 1'(c), !(c >= 6 && c <= 8));
        end
        chk("stall_results", 64'(res8 - base), 64'(5));
        chk("stall_drained", 64'(q8.size()), 64'(0));

        // Reset with three operands in flight.
        for (int c = 0; c < 3; c++) cyc8(1'b1, 8'(8'h40 + c), 8'h11, 1'b0, 1'b1);
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        q8.delete();
        or8 = 1'b1;
        #1;
        chk("midrst_out", 64'({ov8, diff8, bout8, zero8, neg8, ovf8}), 64'(0));
        chk("midrst_ready", 64'(ir8), 64'(1));
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("midrst_idle[%0d]", c), 64'(ov8), 64'(0));
            cyc8(1'b0, 8'h0, 8'h0, 1'b0, 1'b1);
        end
        chk("midrst_diff", 64'({diff8, bout8, zero8, neg8, ovf8}), 64'(0));

        // Random traffic on both widths with random backpressure.
        n8 = 0; n16 = 0; res8 = 0; res16 = 0;
        guard = 0;
        while ((n8 < 10000 || n16 < 10000) && guard < 60000) begin
            cyc(n8 < 10000 && $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                1'($urandom), $urandom_range(0, 3) != 0,
                n16 < 10000 && $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                1'($urandom), $urandom_range(0, 3) != 0);
            guard++;
        end
        guard = 0;
        while ((q8.size() != 0 || q16.size() != 0) && guard < 50) begin
            cyc(1'b0, 8'h0, 8'h0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            guard++;
        end
        chk("rand_accepted8", 64'(n8), 64'(10000));
        chk("rand_accepted16", 64'(n16), 64'(10000));
        chk("rand_results8", 64'(res8), 64'(10000));
        chk("rand_results16", 64'(res16), 64'(10000));
        chk("rand_drained", 64'(q8.size() + q16.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
